// File: rtl/y_scale_rom_pkg.sv
// Shared types and default sizes for the vertical-scale coefficient ROM arbiter.
package y_scale_rom_pkg;

    localparam int ADDR_WIDTH_DEF = 10;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int RD_LATENCY_DEF = 2;
    localparam int TAPS_DEF       = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    typedef struct packed {
        logic valid;
        logic owner;
        logic last;
    } tag_t;

endpackage

// File: rtl/y_scale_rom_arb_if.sv
// Requester, response and ROM-side signals of the coefficient ROM arbiter.
interface y_scale_rom_arb_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    logic                  req0_valid;
    logic                  req1_valid;
    logic [ADDR_WIDTH-1:0] req0_base;
    logic [ADDR_WIDTH-1:0] req1_base;
    logic                  req0_ready;
    logic                  req1_ready;
    logic                  rsp0_valid;
    logic                  rsp1_valid;
    logic                  rsp0_last;
    logic                  rsp1_last;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic                  rom_clk_en;
    logic                  rom_addr_strobe;
    logic                  rom_rd_oce;
    logic                  rom_rst;
    logic [DATA_WIDTH-1:0] rom_rd_data;
    logic                  busy;

    modport slave (
        input  req0_valid, req1_valid, req0_base, req1_base, rom_rd_data,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_last, rsp1_last,
               rsp_data, rom_addr, rom_clk_en, rom_addr_strobe, rom_rd_oce, rom_rst, busy
    );

    modport master (
        output req0_valid, req1_valid, req0_base, req1_base, rom_rd_data,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_last, rsp1_last,
               rsp_data, rom_addr, rom_clk_en, rom_addr_strobe, rom_rd_oce, rom_rst, busy
    );

endinterface

// File: rtl/y_scale_rd_pipe.sv
// Tag delay line matching the ROM read latency; tail lines up with rom_rd_data.
module y_scale_rd_pipe
    import y_scale_rom_pkg::*;
#(
    parameter int RD_LATENCY = RD_LATENCY_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  tag_t tag_i,
    output tag_t tag_o,
    output logic busy_o
);

    tag_t [RD_LATENCY-1:0] pipe_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q <= '0;
        end else begin
            pipe_q[0] <= tag_i;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    always_comb begin
        busy_o = 1'b0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            busy_o = busy_o | pipe_q[i].valid;
        end
    end

    assign tag_o = pipe_q[RD_LATENCY-1];

endmodule

// File: rtl/y_scale_rom_arb.sv
// Round-robin two-port arbiter issuing TAPS-beat read bursts to the shared
// vertical-scale coefficient ROM and routing returning beats to their owner.
module y_scale_rom_arb
    import y_scale_rom_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int RD_LATENCY = RD_LATENCY_DEF,
    parameter int TAPS       = TAPS_DEF
) (
    input  logic clk,
    input  logic rst_n,
    y_scale_rom_arb_if.slave bus
);

    localparam int              IDX_W    = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TAPS - 1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  owner_q, owner_d;
    logic                  served_q, served_d;

    logic grant;
    logic hs;
    logic beat_last;
    logic ready0, ready1;
    logic active;
    logic pipe_busy;
    tag_t push_tag;
    tag_t tail_tag;

    // Tie goes to whoever was not served last; served_q resets to 1 so req0 wins first.
    assign grant     = (bus.req0_valid & bus.req1_valid) ? ~served_q : bus.req1_valid;
    assign hs        = (state_q == ST_IDLE) & (bus.req0_valid | bus.req1_valid);
    assign beat_last = (idx_q == IDX_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (hs)        state_d = ST_BURST;
            ST_BURST: if (beat_last) state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ready0   = 1'b0;
        ready1   = 1'b0;
        push_tag = '0;
        active   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready0 = bus.req0_valid & ~grant;
                ready1 = bus.req1_valid & grant;
            end
            ST_BURST: begin
                push_tag = '{valid: 1'b1, owner: owner_q, last: beat_last};
                active   = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        addr_d   = addr_q;
        idx_d    = idx_q;
        owner_d  = owner_q;
        served_d = served_q;
        if (hs) begin
            addr_d   = grant ? bus.req1_base : bus.req0_base;
            idx_d    = '0;
            owner_d  = grant;
            served_d = grant;
        end else if (state_q == ST_BURST && !beat_last) begin
            addr_d = addr_q + 1'b1;
            idx_d  = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= '0;
            idx_q    <= '0;
            owner_q  <= 1'b0;
            served_q <= 1'b1;
        end else begin
            addr_q   <= addr_d;
            idx_q    <= idx_d;
            owner_q  <= owner_d;
            served_q <= served_d;
        end
    end

    y_scale_rd_pipe #(
        .RD_LATENCY (RD_LATENCY)
    ) u_rd_pipe (
        .clk    (clk),
        .rst_n  (rst_n),
        .tag_i  (push_tag),
        .tag_o  (tail_tag),
        .busy_o (pipe_busy)
    );

    assign bus.req0_ready      = ready0;
    assign bus.req1_ready      = ready1;
    assign bus.rsp0_valid      = tail_tag.valid & ~tail_tag.owner;
    assign bus.rsp1_valid      = tail_tag.valid & tail_tag.owner;
    assign bus.rsp0_last       = tail_tag.valid & ~tail_tag.owner & tail_tag.last;
    assign bus.rsp1_last       = tail_tag.valid & tail_tag.owner & tail_tag.last;
    assign bus.rsp_data        = bus.rom_rd_data;
    assign bus.rom_addr        = addr_q;
    assign bus.rom_clk_en      = active | pipe_busy;
    assign bus.busy            = active | pipe_busy;
    assign bus.rom_addr_strobe = 1'b0;
    assign bus.rom_rd_oce      = 1'b1;
    assign bus.rom_rst         = ~rst_n;

endmodule

// File: tb/tb_y_scale_rom_arb.sv
// Three arbiters (read latency 1, 2, 3) share one request stream; each has its
// own ROM model and response scoreboard.
module tb_y_scale_rom_arb;

    localparam int AW   = 10;
    localparam int DW   = 32;
    localparam int TAPS = 4;

    typedef struct {
        logic        owner;
        logic        last;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          v0 = 1'b0, v1 = 1'b0;
    logic [AW-1:0] b0 = '0, b1 = '0;
    int            cyc = 0;
    int            checks = 0;
    int            failures = 0;
    exp_t          sbq[3][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    y_scale_rom_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();
    y_scale_rom_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus2 ();
    y_scale_rom_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus3 ();

    y_scale_rom_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1), .TAPS(TAPS))
        u_dut_l1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    y_scale_rom_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(2), .TAPS(TAPS))
        u_dut_l2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
    y_scale_rom_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(3), .TAPS(TAPS))
        u_dut_l3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    assign bus1.req0_valid = v0;  assign bus1.req1_valid = v1;
    assign bus1.req0_base  = b0;  assign bus1.req1_base  = b1;
    assign bus2.req0_valid = v0;  assign bus2.req1_valid = v1;
    assign bus2.req0_base  = b0;  assign bus2.req1_base  = b1;
    assign bus3.req0_valid = v0;  assign bus3.req1_valid = v1;
    assign bus3.req0_base  = b0;  assign bus3.req1_base  = b1;

    function automatic logic [31:0] rom_f(input logic [AW-1:0] a);
        return {a, ~a, 12'h5A5};
    endfunction

    // ROM models: registered read with clock enable, depth = read latency
    logic [31:0] r1_q;
    logic [31:0] r2_q [2];
    logic [31:0] r3_q [3];
    always @(posedge clk) if (bus1.rom_clk_en) r1_q <= rom_f(bus1.rom_addr);
    always @(posedge clk) if (bus2.rom_clk_en) begin
        r2_q[0] <= rom_f(bus2.rom_addr);
        r2_q[1] <= r2_q[0];
    end
    always @(posedge clk) if (bus3.rom_clk_en) begin
        r3_q[0] <= rom_f(bus3.rom_addr);
        r3_q[1] <= r3_q[0];
        r3_q[2] <= r3_q[1];
    end
    assign bus1.rom_rd_data = r1_q;
    assign bus2.rom_rd_data = r2_q[1];
    assign bus3.rom_rd_data = r3_q[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_burst(input logic owner, input logic [AW-1:0] base, input int t);
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < TAPS; i++) begin
                exp_t          e;
                logic [AW-1:0] a;
                a       = base + AW'(i);
                e.owner = owner;
                e.last  = (i == TAPS - 1);
                e.data  = rom_f(a);
                e.cyc   = t + 1 + i + (k + 1);
                sbq[k].push_back(e);
            end
        end
    endtask

    // Wait for the next handshake on the latency-2 instance and check who won.
    task automatic take(input logic exp_owner, input string name);
        bit got;
        got = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            if ((v0 && bus2.req0_ready) || (v1 && bus2.req1_ready)) begin
                got = 1'b1;
                chk(name, {30'd0, bus2.req1_ready, bus2.req0_ready}, exp_owner ? 32'd2 : 32'd1);
                push_burst(exp_owner, exp_owner ? b1 : b0, cyc);
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL %s actual=no_handshake required=handshake_within_40_cycles", name);
        end
    endtask

    task automatic mon(input int k, input logic rv0, input logic rv1,
                       input logic rl0, input logic rl1, input logic [31:0] d);
        exp_t e;
        if (rv0 && rv1) begin
            checks++;
            failures++;
            $display("FAIL rsp_both_dut%0d actual=rsp0&rsp1 required=at_most_one (cycle %0d)", k, cyc);
        end else if (rv0 || rv1) begin
            checks++;
            if (sbq[k].size() == 0) begin
                failures++;
                $display("FAIL rsp_unexpected_dut%0d actual owner=%0d data=%h required=no_rsp (cycle %0d)",
                         k, rv1, d, cyc);
            end else begin
                e = sbq[k].pop_front();
                if (e.owner !== rv1 || e.last !== (rv1 ? rl1 : rl0) || e.data !== d || e.cyc != cyc) begin
                    failures++;
                    $display("FAIL rsp_dut%0d actual owner=%0d last=%0d data=%h cyc=%0d required owner=%0d last=%0d data=%h cyc=%0d",
                             k, rv1, rv1 ? rl1 : rl0, d, cyc, e.owner, e.last, e.data, e.cyc);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, bus1.rsp0_valid, bus1.rsp1_valid, bus1.rsp0_last, bus1.rsp1_last, bus1.rsp_data);
        mon(1, bus2.rsp0_valid, bus2.rsp1_valid, bus2.rsp0_last, bus2.rsp1_last, bus2.rsp_data);
        mon(2, bus3.rsp0_valid, bus3.rsp1_valid, bus3.rsp0_last, bus3.rsp1_last, bus3.rsp_data);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // reset state
        step(2);
        @(negedge clk);
        chk("rst_rom_addr", {22'd0, bus2.rom_addr}, 32'd0);
        chk("rst_clk_en", {29'd0, bus1.rom_clk_en, bus2.rom_clk_en, bus3.rom_clk_en}, 32'd0);
        chk("rst_busy", {29'd0, bus1.busy, bus2.busy, bus3.busy}, 32'd0);
        chk("rst_rom_rst", {31'd0, bus2.rom_rst}, 32'd1);
        chk("rst_oce", {31'd0, bus2.rom_rd_oce}, 32'd1);
        chk("rst_strobe", {31'd0, bus2.rom_addr_strobe}, 32'd0);
        step(1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("run_rom_rst", {31'd0, bus2.rom_rst}, 32'd0);
        step(1);

        // tie straight after reset: req0 first, then req1
        b0 = 10'h020; b1 = 10'h040; v0 = 1'b1; v1 = 1'b1;
        take(1'b0, "tie_first");
        step(1); v0 = 1'b0;
        take(1'b1, "tie_second");
        step(1); v1 = 1'b0;
        step(8);

        // both held: alternate 0,1,0,1
        b0 = 10'h100; b1 = 10'h180; v0 = 1'b1; v1 = 1'b1;
        take(1'b0, "alt_0");
        take(1'b1, "alt_1");
        take(1'b0, "alt_2");
        take(1'b1, "alt_3");
        step(1); v0 = 1'b0; v1 = 1'b0;
        step(8);

        // single req0 at 0x010
        b0 = 10'h010; v0 = 1'b1;
        take(1'b0, "single_req0");
        step(1); v0 = 1'b0;
        step(8);

        // address wrap through 0x3FF
        b1 = 10'h3FE; v1 = 1'b1;
        take(1'b1, "wrap_req1");
        step(1); v1 = 1'b0;
        step(8);

        // back-to-back req0 then req1
        b0 = 10'h2A0; b1 = 10'h155; v0 = 1'b1;
        take(1'b0, "b2b_req0");
        step(1); v0 = 1'b0; v1 = 1'b1;
        take(1'b1, "b2b_req1");
        step(1); v1 = 1'b0;
        step(8);

        // reset during beat 2 of a burst
        b0 = 10'h0F0; v0 = 1'b1;
        take(1'b0, "pre_reset_req0");
        step(1); v0 = 1'b0;
        step(2);
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) sbq[k].delete();
        @(negedge clk);
        chk("midrst_clk_en", {29'd0, bus1.rom_clk_en, bus2.rom_clk_en, bus3.rom_clk_en}, 32'd0);
        chk("midrst_busy", {29'd0, bus1.busy, bus2.busy, bus3.busy}, 32'd0);
        chk("midrst_rom_addr", {22'd0, bus2.rom_addr}, 32'd0);
        step(2);
        rst_n = 1'b1;
        step(1);
        b1 = 10'h200; v1 = 1'b1;
        take(1'b1, "post_rst_req1");
        step(1); v1 = 1'b0;
        step(8);
        b0 = 10'h080; b1 = 10'h0C0; v0 = 1'b1; v1 = 1'b1;
        take(1'b0, "post_rst_tie");
        step(1); v0 = 1'b0;
        take(1'b1, "post_rst_tie_second");
        step(1); v1 = 1'b0;
        step(10);

        // long idle
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            chk("idle_clk_en_busy", {30'd0, bus2.rom_clk_en, bus2.busy}, 32'd0);
            chk("idle_ready", {30'd0, bus2.req1_ready, bus2.req0_ready}, 32'd0);
        end

        step(4);
        for (int k = 0; k < 3; k++) chk($sformatf("sb_empty_dut%0d", k), sbq[k].size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
